ram_dp_arbiter: RTL

- Shares one 64x8 true-dual-port RAM between four requesters.
- Each cycle the arbiter grants up to two requests, one per RAM port, in round-robin order.
- Same-address hazards are blocked: two requests to one address are never granted together if either is a write.
- Read data returns one cycle after grant, steered to the requester that issued the read.

---
 rtl/ram_dp_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/ram_dp_arbiter.sv
// Round-robin arbiter sharing one 64x8 true-dual-port RAM among four requesters.
// Grants up to two requests per cycle, one per port, and blocks same-address hazards involving writes.
module ram_dp_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 6,
  parameter int DW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [NREQ*DW-1:0] rdata,
  output logic               ram_we_a,
  output logic               ram_we_b,
  output logic [AW-1:0]      ram_addr_a,
  output logic [AW-1:0]      ram_addr_b,
  output logic [DW-1:0]      ram_data_a,
  output logic [DW-1:0]      ram_data_b,
  input  logic [DW-1:0]      ram_q_a,
  input  logic [DW-1:0]      ram_q_b
);

  logic [1:0] ptr;
  logic [1:0] rsel_a, rsel_b;
  logic       rv_a, rv_b;

  logic [1:0] sel_a, sel_b, idx;
  logic       has_a, has_b;
  logic       grant_a, grant_b;

  always_comb begin
    has_a = 1'b0;
    sel_a = ptr;
    has_b = 1'b0;
    sel_b = ptr;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!has_a && req[idx]) begin
        has_a = 1'b1;
        sel_a = idx;
      end
    end
    // B takes the next requester after A that does not collide with A on a write
    for (int k = 1; k < 4; k++) begin
      idx = sel_a + 2'(k);
      if (has_a && !has_b && req[idx] &&
          ((addr[idx*AW +: AW] != addr[sel_a*AW +: AW]) || (!we[idx] && !we[sel_a]))) begin
        has_b = 1'b1;
        sel_b = idx;
      end
    end
  end

  assign grant_a = has_a & ~rst;
  assign grant_b = has_b & ~rst;

  always_comb begin
    gnt = '0;
    if (grant_a) gnt[sel_a] = 1'b1;
    if (grant_b) gnt[sel_b] = 1'b1;
  end

  always_comb begin
    ram_we_a   = 1'b0;
    ram_addr_a = '0;
    ram_data_a = '0;
    ram_we_b   = 1'b0;
    ram_addr_b = '0;
    ram_data_b = '0;
    if (grant_a) begin
      ram_we_a   = we[sel_a];
      ram_addr_a = addr[sel_a*AW +: AW];
      ram_data_a = wdata[sel_a*DW +: DW];
    end
    if (grant_b) begin
      ram_we_b   = we[sel_b];
      ram_addr_b = addr[sel_b*AW +: AW];
      ram_data_b = wdata[sel_b*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= 2'd0;
      rv_a   <= 1'b0;
      rv_b   <= 1'b0;
      rsel_a <= 2'd0;
      rsel_b <= 2'd0;
    end else begin
      if (grant_b)      ptr <= sel_b + 2'd1;
      else if (grant_a) ptr <= sel_a + 2'd1;
      rv_a   <= grant_a & ~we[sel_a];
      rv_b   <= grant_b & ~we[sel_b];
      rsel_a <= sel_a;
      rsel_b <= sel_b;
    end
  end

  // Returns are suppressed while reset is held so an in-flight read is dropped immediately
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (!rst && rv_a) begin
      rvalid[rsel_a]            = 1'b1;
      rdata[rsel_a*DW +: DW]    = ram_q_a;
    end
    if (!rst && rv_b) begin
      rvalid[rsel_b]            = 1'b1;
      rdata[rsel_b*DW +: DW]    = ram_q_b;
    end
  end

endmodule
